pool_frame_buffer: RTL and testbench

- Downstream stage of the pooling block: captures the serial pooled stream (data, valid, end-of-matrix) into a ping-pong pair of frame banks.
- Each full pooled feature map is replayed to the next layer over a valid/ready handshake.
- Decouples pooler throughput from consumer back-pressure, so the pooler can fill one bank while the other drains.

---
 rtl/pool_frame_buffer_if.sv | 24 ++
 rtl/pool_frame_buffer.sv | 97 +++++++++
 tb/tb_pool_frame_buffer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pool_frame_buffer_if.sv
// pool_frame_buffer_if: pooled-stream capture inputs and the replay handshake of the frame buffer.
interface pool_frame_buffer_if #(
  parameter int N = 8
);
  logic         ce;
  logic [N-1:0] data_in;
  logic         valid_in;
  logic         end_in;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         frame_done;
  logic         overflow;
  logic         frame_err;
  modport master (
    output ce, data_in, valid_in, end_in, out_ready,
    input  out_data, out_valid, out_last, frame_done, overflow, frame_err
  );
  modport slave (
    input  ce, data_in, valid_in, end_in, out_ready,
    output out_data, out_valid, out_last, frame_done, overflow, frame_err
  );
endinterface

// File: rtl/pool_frame_buffer.sv
// pool_frame_buffer: ping-pong capture of pooled feature maps, replayed over valid/ready at 1 word/clk.
module pool_frame_buffer #(
  parameter int N = 8,
  parameter int m = 12,
  parameter int p = 3
) (
  input logic               clk,
  input logic               master_rst,
  pool_frame_buffer_if.slave bus
);
  localparam int OD = m / p;
  localparam int D  = OD * OD;
  localparam int AW = (D > 1) ? $clog2(D) : 1;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} rstate_t;
  logic [N-1:0]       mem_q [2][D];
  logic [1:0]         full_q;
  logic [1:0][AW:0]   len_q;
  logic               wr_bank_q, rd_bank_q;
  logic [AW-1:0]      wr_idx_q, rd_idx_q, rd_idx_d;
  rstate_t            state_q;
  logic [N-1:0]       out_data_q;
  logic               out_valid_q, out_last_q, frame_done_q, overflow_q, frame_err_q;
  logic               wr_ev, wr_ok, close_full, close_short, hs;
  logic [AW:0]        wr_cnt;
  assign wr_ev       = bus.ce && bus.valid_in;
  assign wr_ok       = wr_ev && !full_q[wr_bank_q];
  assign wr_cnt      = {1'b0, wr_idx_q} + {{AW{1'b0}}, wr_ok};
  assign close_full  = wr_ok && (wr_idx_q == AW'(D - 1));
  assign close_short = bus.ce && bus.end_in && (wr_cnt != '0) && (wr_cnt != (AW+1)'(D));
  assign hs          = out_valid_q && bus.out_ready;
  assign rd_idx_d    = rd_idx_q + AW'(1);
  always_ff @(posedge clk)
    if (wr_ok) mem_q[wr_bank_q][wr_idx_q] <= bus.data_in;
  // A bank freed by the reader only becomes writable the cycle after; the writer sees the old full flag.
  always_ff @(posedge clk) begin
    if (!master_rst) begin
      full_q       <= '0;
      len_q        <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      state_q      <= R_IDLE;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (wr_ev && !wr_ok) overflow_q <= 1'b1;
      if (close_short) frame_err_q <= 1'b1;
      if (close_full || close_short) begin
        full_q[wr_bank_q] <= 1'b1;
        len_q[wr_bank_q]  <= wr_cnt;
        wr_idx_q          <= '0;
        wr_bank_q         <= ~wr_bank_q;
      end else if (wr_ok) begin
        wr_idx_q <= wr_idx_q + AW'(1);
      end
      case (state_q)
        R_IDLE: if (full_q[rd_bank_q]) begin
          rd_idx_q <= '0;
          state_q  <= R_FETCH;
        end
        R_FETCH: begin
          out_data_q  <= mem_q[rd_bank_q][rd_idx_q];
          out_valid_q <= 1'b1;
          out_last_q  <= len_q[rd_bank_q] == (AW+1)'(1);
          state_q     <= R_STREAM;
        end
        R_STREAM: if (hs) begin
          if (out_last_q) begin
            out_valid_q       <= 1'b0;
            out_last_q        <= 1'b0;
            full_q[rd_bank_q] <= 1'b0;
            rd_bank_q         <= ~rd_bank_q;
            frame_done_q      <= 1'b1;
            state_q           <= R_IDLE;
          end else begin
            rd_idx_q   <= rd_idx_d;
            out_data_q <= mem_q[rd_bank_q][rd_idx_d];
            out_last_q <= {1'b0, rd_idx_d} == len_q[rd_bank_q] - (AW+1)'(1);
          end
        end
        default: state_q <= R_IDLE;
      endcase
    end
  end
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overflow   = overflow_q;
  assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_pool_frame_buffer.sv
// tb_pool_frame_buffer: directed checks of capture, replay, back-pressure, ping-pong, short frames and reset.
module tb_pool_frame_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  pool_frame_buffer_if #(.N(8)) bus();
  pool_frame_buffer #(.N(8), .m(12), .p(3)) dut (
    .clk(clk),
    .master_rst(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input int v, input logic e);
    bus.valid_in = 1'b1;
    bus.data_in  = v[7:0];
    bus.end_in   = e;
    tick();
    bus.valid_in = 1'b0;
    bus.end_in   = 1'b0;
  endtask
  task automatic drain(input string tag, input int first, input int len, input int nfr);
    int exp = first;
    int got = 0;
    int fd = 0;
    logic v;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 200 && got < len * nfr; c++) begin
      v = bus.out_valid;
      if (v) begin
        chk({tag, "_data"}, {24'd0, bus.out_data}, exp & 32'hff);
        chk({tag, "_last"}, {31'd0, bus.out_last}, ((got % len) == len - 1) ? 32'd1 : 32'd0);
      end
      tick();
      if (v) begin
        got++;
        exp++;
      end
      if (bus.frame_done) fd++;
    end
    chk({tag, "_count"}, got, len * nfr);
    chk({tag, "_frame_done"}, fd, nfr);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, 0);
    chk({tag, "_last"}, {31'd0, bus.out_last}, 0);
    chk({tag, "_done"}, {31'd0, bus.frame_done}, 0);
    chk({tag, "_ovf"}, {31'd0, bus.overflow}, 0);
    chk({tag, "_ferr"}, {31'd0, bus.frame_err}, 0);
    chk({tag, "_data"}, {24'd0, bus.out_data}, 0);
  endtask
  initial begin
    int hs;
    int fd;
    int exp;
    logic v;
    logic r;
    bus.ce = 1'b1;
    bus.valid_in = 1'b0;
    bus.end_in = 1'b0;
    bus.data_in = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk_zero("reset");
    rst_n = 1'b1;
    // Full frame with the consumer always ready.
    for (int i = 1; i <= 16; i++) wr(i, 1'b0);
    chk("lat_t0", {31'd0, bus.out_valid}, 0);
    tick();
    chk("lat_t1", {31'd0, bus.out_valid}, 0);
    tick();
    for (int k = 1; k <= 16; k++) begin
      chk("s1_valid", {31'd0, bus.out_valid}, 1);
      chk("s1_data", {24'd0, bus.out_data}, k);
      chk("s1_last", {31'd0, bus.out_last}, (k == 16) ? 32'd1 : 32'd0);
      chk("s1_done_low", {31'd0, bus.frame_done}, 0);
      tick();
    end
    chk("s1_done", {31'd0, bus.frame_done}, 1);
    chk("s1_valid_off", {31'd0, bus.out_valid}, 0);
    tick();
    chk("s1_done_pulse", {31'd0, bus.frame_done}, 0);
    chk("s1_ovf", {31'd0, bus.overflow}, 0);
    // Back-pressure with ready pattern 1,0,0,1.
    for (int i = 1; i <= 16; i++) wr(i, 1'b0);
    hs = 0;
    fd = 0;
    exp = 1;
    for (int c = 0; c < 200 && hs < 16; c++) begin
      r = (c % 4 == 0) || (c % 4 == 3);
      bus.out_ready = r;
      v = bus.out_valid;
      if (v) begin
        chk("bp_data", {24'd0, bus.out_data}, exp);
        chk("bp_last", {31'd0, bus.out_last}, (exp == 16) ? 32'd1 : 32'd0);
      end
      tick();
      if (v && r) begin
        hs++;
        exp++;
      end
      if (bus.frame_done) fd++;
    end
    chk("bp_handshakes", hs, 16);
    chk("bp_frame_done", fd, 1);
    bus.out_ready = 1'b1;
    tick();
    // Ping-pong: both banks fill, the third frame is dropped.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 48; i++) wr(i, 1'b0);
    chk("pp_overflow", {31'd0, bus.overflow}, 1);
    chk("pp_hold_valid", {31'd0, bus.out_valid}, 1);
    chk("pp_hold_data", {24'd0, bus.out_data}, 0);
    drain("pp", 0, 16, 2);
    for (int i = 0; i < 4; i++) tick();
    chk("pp_no_third", {31'd0, bus.out_valid}, 0);
    // Short frame closed by end_in after 5 words.
    chk("sf_ferr_before", {31'd0, bus.frame_err}, 0);
    for (int i = 0; i < 5; i++) wr(100 + i, i == 4);
    chk("sf_ferr", {31'd0, bus.frame_err}, 1);
    drain("sf", 100, 5, 1);
    // ce gating: nothing captured while ce is low.
    bus.ce = 1'b0;
    for (int i = 0; i < 10; i++) wr(77, i == 9);
    bus.ce = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("ce_no_out", {31'd0, bus.out_valid}, 0);
    // Reset during a stream, then a fresh frame from bank 0.
    for (int i = 0; i < 16; i++) wr(200 + i, 1'b0);
    tick();
    tick();
    chk("rs_first", {24'd0, bus.out_data}, 200);
    tick();
    tick();
    chk("rs_third", {24'd0, bus.out_data}, 202);
    rst_n = 1'b0;
    tick();
    chk_zero("midreset");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("rs_discard", {31'd0, bus.out_valid}, 0);
    for (int i = 0; i < 16; i++) wr(50 + i, 1'b0);
    drain("rs", 50, 16, 1);
    chk("rs_ovf", {31'd0, bus.overflow}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
